// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end feeding a serial bit detector
// One shifting word plus one holding buffer so consecutive words stream with no idle bit.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             transfer;
    logic             cur_bit;
    logic [WIDTH-1:0] shifted;

    assign in_ready = !hold_full_q && !reset;
    assign transfer = in_valid && in_ready;

    // The bit on x always sits at the outgoing end of shift_q.
    assign cur_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (transfer) begin
                        shift_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (transfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign x_valid = (state_q == SHIFT);
    assign x       = x_valid ? cur_bit : IDLE_BIT;
    assign last    = x_valid && (cnt_q == LAST_CNT);
    assign busy    = x_valid || hold_full_q;

endmodule
